mips_instr_encoder: RTL and testbench

Program-loader block for the MIPS core: accepts decoded instruction fields over a valid/ready stream, assembles them into 32-bit MIPS R/I/J words, and writes them sequentially into instruction memory. It produces the opcode/field encoding that the control unit and datapath later decode. It sits between the testbench or boot source and the instruction memory write port.

---
 rtl/mips_instr_encoder.sv | 168 ++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
// Program loader: takes decoded MIPS instruction fields over a valid/ready
// stream, validates the opcode against the instruction format, packs the
// fields into a 32-bit R/I/J word and writes the words one by one into
// instruction memory, starting at BASE_ADDR.

module mips_instr_encoder #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    // Instruction format codes carried on in_fmt
    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_J = 2'd2;

    // Address and count increments sized to their registers
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic [31:0]       word_q;
    logic              last_q;
    logic              done_q;
    logic              err_q;

    logic              fieldsLegal;
    logic [31:0]       encodedWord;

    // Decide whether the opcode presented on the input is legal for its format
    always_comb begin
        fieldsLegal = 1'b0;
        case (in_fmt)
            FMT_R: fieldsLegal = (in_op == 6'b000000);
            FMT_I: begin
                case (in_op)
                    6'b001000, // addi
                    6'b001001, // addiu
                    6'b001100, // andi
                    6'b000100, // beq
                    6'b000101, // bne
                    6'b100100, // lbu
                    6'b100101, // lhu
                    6'b001111, // lui
                    6'b100011, // lw
                    6'b001101, // ori
                    6'b001010, // slti
                    6'b001011, // sltiu
                    6'b101000, // sb
                    6'b101001, // sh
                    6'b101011: // sw
                        fieldsLegal = 1'b1;
                    default:
                        fieldsLegal = 1'b0;
                endcase
            end
            FMT_J: fieldsLegal = (in_op == 6'b000010) || (in_op == 6'b000011);
            default: fieldsLegal = 1'b0;
        endcase
    end

    // Pack the input fields into the 32-bit word for the presented format
    always_comb begin
        encodedWord = 32'd0;
        case (in_fmt)
            FMT_R:   encodedWord = {in_op, in_rs, in_rt, in_rd, in_shamt, in_funct};
            FMT_I:   encodedWord = {in_op, in_rs, in_rt, in_imm};
            FMT_J:   encodedWord = {in_op, in_target};
            default: encodedWord = 32'd0;
        endcase
    end

    // Load sequencer: accept a bundle, write it for one cycle, then either
    // go back for the next bundle or stop in DONE/ERROR with a sticky flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            word_q  <= 32'd0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q <= S_ACCEPT;
                        addr_q  <= BASE_ADDR;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) begin
                        if (fieldsLegal) begin
                            word_q  <= encodedWord;
                            last_q  <= in_last;
                            state_q <= S_WRITE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_ERROR;
                        end
                    end
                end
                S_WRITE: begin
                    count_q <= count_q + COUNT_ONE;
                    addr_q  <= addr_q + ADDR_ONE;
                    if (last_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (addr_q == ADDR_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERROR;
                    end else begin
                        state_q <= S_ACCEPT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_ACCEPT);
    assign mem_we    = (state_q == S_WRITE);
    assign busy      = (state_q == S_ACCEPT) || (state_q == S_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign count     = count_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder
// Directed bench for the program loader, built with a 4-word memory so that
// the memory-full path is reachable with a handful of bundles.

module tb_mips_instr_encoder;

    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_fmt = 2'd0;
    logic [5:0]        in_op = 6'd0;
    logic [4:0]        in_rs = 5'd0;
    logic [4:0]        in_rt = 5'd0;
    logic [4:0]        in_rd = 5'd0;
    logic [4:0]        in_shamt = 5'd0;
    logic [5:0]        in_funct = 6'd0;
    logic [15:0]       in_imm = 16'd0;
    logic [25:0]       in_target = 26'd0;
    logic              in_last = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;

    int vectors = 0;
    int miscompares = 0;

    // Hand-packed R words used by the memory-full run: rs=i, rd=i+4, funct=0x21
    logic [31:0] fillWord [4];

    mips_instr_encoder #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR('0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_fmt   (in_fmt),
        .in_op    (in_op),
        .in_rs    (in_rs),
        .in_rt    (in_rt),
        .in_rd    (in_rd),
        .in_shamt (in_shamt),
        .in_funct (in_funct),
        .in_imm   (in_imm),
        .in_target(in_target),
        .in_last  (in_last),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] fmt,
                                 input logic [5:0] op, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [4:0] shamt, input logic [5:0] funct,
                                 input logic [15:0] imm, input logic [25:0] target,
                                 input logic last);
        in_valid  = valid;
        in_fmt    = fmt;
        in_op     = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_shamt  = shamt;
        in_funct  = funct;
        in_imm    = imm;
        in_target = target;
        in_last   = last;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic expectWrite(input string tag, input logic [ADDR_W-1:0] addr,
                               input logic [31:0] data);
        checkOutput({tag, "_we"}, {31'd0, mem_we}, 32'd1);
        checkOutput({tag, "_addr"}, {30'd0, mem_addr}, {30'd0, addr});
        checkOutput({tag, "_wdata"}, mem_wdata, data);
        checkOutput({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        fillWord[0] = 32'h0000_2021;
        fillWord[1] = 32'h0020_2821;
        fillWord[2] = 32'h0040_3021;
        fillWord[3] = 32'h0060_3821;

        // Reset values
        step();
        step();
        checkOutput("rst_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_addr", {30'd0, mem_addr}, 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_count", {29'd0, count}, 32'd0);
        rst_n = 1'b1;
        step();

        // Single R-type add, last
        pulseStart();
        checkOutput("r_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("r_busy", {31'd0, busy}, 32'd1);
        applyStimulus(1'b1, 2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1'b1);
        step();
        expectWrite("r_wr", 2'd0, 32'h0022_1820);
        applyStimulus(1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
        step();
        checkOutput("r_done", {31'd0, done}, 32'd1);
        checkOutput("r_count", {29'd0, count}, 32'd1);
        checkOutput("r_we_off", {31'd0, mem_we}, 32'd0);
        checkOutput("r_busy_off", {31'd0, busy}, 32'd0);

        // lw, j, beq with valid held high
        pulseStart();
        checkOutput("seq_done_clr", {31'd0, done}, 32'd0);
        checkOutput("seq_count0", {29'd0, count}, 32'd0);
        applyStimulus(1'b1, 2'd1, 6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0);
        step();
        expectWrite("seq_lw", 2'd0, 32'h8FA8_0004);
        applyStimulus(1'b1, 2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h010_0000, 1'b0);
        step();
        checkOutput("seq_gap1_we", {31'd0, mem_we}, 32'd0);
        checkOutput("seq_gap1_ready", {31'd0, in_ready}, 32'd1);
        step();
        expectWrite("seq_j", 2'd1, 32'h0810_0000);
        applyStimulus(1'b1, 2'd1, 6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b1);
        step();
        checkOutput("seq_gap2_we", {31'd0, mem_we}, 32'd0);
        step();
        expectWrite("seq_beq", 2'd2, 32'h1022_FFFF);
        applyStimulus(1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
        step();
        checkOutput("seq_done", {31'd0, done}, 32'd1);
        checkOutput("seq_count", {29'd0, count}, 32'd3);

        // I-format carrying a J opcode is rejected
        pulseStart();
        applyStimulus(1'b1, 2'd1, 6'b000010, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0);
        step();
        checkOutput("bad_we", {31'd0, mem_we}, 32'd0);
        checkOutput("bad_err", {31'd0, err}, 32'd1);
        checkOutput("bad_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("bad_count", {29'd0, count}, 32'd0);
        applyStimulus(1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
        step();
        checkOutput("bad_err_sticky", {31'd0, err}, 32'd1);

        // Restart, then fill all four words without last
        pulseStart();
        checkOutput("fill_err_clr", {31'd0, err}, 32'd0);
        checkOutput("fill_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("fill_addr0", {30'd0, mem_addr}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'd0, 6'd0, 5'(i), 5'd0, 5'(i + 4), 5'd0, 6'h21, 16'd0, 26'd0, 1'b0);
            step();
            expectWrite($sformatf("fill_w%0d", i), 2'(i), fillWord[i]);
            step();
        end
        checkOutput("fill_err", {31'd0, err}, 32'd1);
        checkOutput("fill_count", {29'd0, count}, 32'd4);
        checkOutput("fill_ready_off", {31'd0, in_ready}, 32'd0);
        checkOutput("fill_addr_wrap", {30'd0, mem_addr}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("fill_fifth_we%0d", i), {31'd0, mem_we}, 32'd0);
        end
        applyStimulus(1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);

        // Asynchronous reset during the second write
        pulseStart();
        applyStimulus(1'b1, 2'd1, 6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0);
        step();
        expectWrite("ar_w0", 2'd0, 32'h8FA8_0004);
        applyStimulus(1'b1, 2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h010_0000, 1'b0);
        step();
        step();
        expectWrite("ar_w1", 2'd1, 32'h0810_0000);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_we", {31'd0, mem_we}, 32'd0);
        checkOutput("ar_addr", {30'd0, mem_addr}, 32'd0);
        checkOutput("ar_wdata", mem_wdata, 32'd0);
        checkOutput("ar_count", {29'd0, count}, 32'd0);
        checkOutput("ar_busy", {31'd0, busy}, 32'd0);
        checkOutput("ar_ready", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        pulseStart();
        applyStimulus(1'b1, 2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0);
        step();
        expectWrite("ar_reload", 2'd0, 32'h0022_1820);
        applyStimulus(1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
        step();

        // start pulsed during ACCEPT with no valid data is ignored
        checkOutput("ign_ready_pre", {31'd0, in_ready}, 32'd1);
        pulseStart();
        checkOutput("ign_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("ign_count", {29'd0, count}, 32'd1);
        checkOutput("ign_addr", {30'd0, mem_addr}, 32'd1);
        applyStimulus(1'b1, 2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h000_0040, 1'b1);
        step();
        expectWrite("ign_jal", 2'd1, 32'h0C00_0040);
        applyStimulus(1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
        step();
        checkOutput("ign_done", {31'd0, done}, 32'd1);
        checkOutput("ign_count_end", {29'd0, count}, 32'd2);

        // Illegal format code
        pulseStart();
        applyStimulus(1'b1, 2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
        step();
        checkOutput("fmt3_err", {31'd0, err}, 32'd1);
        checkOutput("fmt3_done", {31'd0, done}, 32'd0);
        checkOutput("fmt3_we", {31'd0, mem_we}, 32'd0);
        applyStimulus(1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
